// File: rtl/cl_dbg_pkg.sv
// Package: cl_dbg_pkg
// Shared definitions for the PairHMM debug counter bank.
//  - Channel index assignments for the default six-channel bank.
//  - Default channel count and the natural 32-bit counter type.
//  - Read-mux selection encoding used by cl_dbg_counter_bank.
package cl_dbg_pkg;

   localparam int unsigned DBG_CH_AXI_RD_ISS  = 32'd0;
   localparam int unsigned DBG_CH_AXI_RD_RSP  = 32'd1;
   localparam int unsigned DBG_CH_AXI_WR_ISS  = 32'd2;
   localparam int unsigned DBG_CH_AXI_WR_RSP  = 32'd3;
   localparam int unsigned DBG_CH_JOBS        = 32'd4;
   localparam int unsigned DBG_CH_RESULTS     = 32'd5;

   localparam int unsigned DBG_NUM_CH_DEFAULT = 32'd6;

   typedef logic [31:0] dbg_cnt_t;

   // What the read port returns for the current address
   typedef enum logic [1:0] {
      RD_SEL_CNT  = 2'd0,
      RD_SEL_OVF  = 2'd1,
      RD_SEL_ZERO = 2'd2
   } rd_sel_e;

endpackage : cl_dbg_pkg

// File: rtl/cl_dbg_counter.sv
// Module: cl_dbg_counter
// One debug event counter channel: counter, sticky overflow flag and, when
// CL_DBG_SNAPSHOT_EN is defined, a shadow register loaded by snap_i.
// Ports:
//  clk_main_a0  in   clock, rising edge
//  rst_main_n   in   asynchronous active-low reset
//  cnt_en_i     in   global count enable (clear is not gated by it)
//  inc_i        in   +1 event strobe for this channel
//  clr_i        in   clear strobe for this channel (already mask-qualified)
//  snap_i       in   snapshot strobe (ignored without CL_DBG_SNAPSHOT_EN)
//  rd_val_o     out  value presented to the read mux (shadow or live count)
//  ovf_o        out  sticky overflow flag
// Configuration macro: CL_DBG_SNAPSHOT_EN
module cl_dbg_counter
   import cl_dbg_pkg::*;
#(
   parameter int unsigned CNT_W     = 32'd32,
   parameter int unsigned WRAP_MODE = 32'd0
) (
   input  logic             clk_main_a0,
   input  logic             rst_main_n,
   input  logic             cnt_en_i,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic             snap_i,
   output logic [CNT_W-1:0] rd_val_o,
   output logic             ovf_o
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   // Value loaded when an increment hits all-ones: wrap to zero or stick
   localparam logic [CNT_W-1:0] CNT_TOP_NEXT = (WRAP_MODE != 32'd0) ? CNT_ZERO : CNT_MAX;

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_r;
   logic             ovf_nxt_s;

   // Next-state: clear beats increment; overflow is sticky until cleared
   always_comb begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_r;
      if (clr_i) begin
         cnt_nxt_s = CNT_ZERO;
         ovf_nxt_s = 1'b0;
      end else if (cnt_en_i && inc_i) begin
         if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = CNT_TOP_NEXT;
            ovf_nxt_s = 1'b1;
         end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            ovf_nxt_s = ovf_r;
         end
      end else begin
         cnt_nxt_s = cnt_r;
         ovf_nxt_s = ovf_r;
      end
   end

   // Counter and overflow state registers
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         cnt_r <= CNT_ZERO;
         ovf_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         ovf_r <= ovf_nxt_s;
      end
   end

   assign ovf_o = ovf_r;

`ifdef CL_DBG_SNAPSHOT_EN
   logic [CNT_W-1:0] shadow_r;

   // Shadow captures the pre-update count so a same-edge inc/clr is not seen
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         shadow_r <= CNT_ZERO;
      end else if (snap_i) begin
         shadow_r <= cnt_r;
      end else begin
         shadow_r <= shadow_r;
      end
   end

   assign rd_val_o = shadow_r;
`else
   logic snap_unused_s;

   assign snap_unused_s = snap_i;
   assign rd_val_o      = cnt_r;
`endif

endmodule : cl_dbg_counter

// File: rtl/cl_dbg_counter_bank.sv
// Module: cl_dbg_counter_bank
// Bank of NUM_CH debug event counters for the PairHMM datapath with a
// registered one-cycle-latency read port for the CL register slave.
// Ports:
//  clk_main_a0  in   clock, rising edge
//  rst_main_n   in   asynchronous active-low reset
//  cnt_en_i     in   global enable; 0 freezes all counters (clear still acts)
//  inc_i        in   per-channel +1 event strobes
//  clr_i        in   clear strobe, qualified by clr_mask_i
//  clr_mask_i   in   channels cleared when clr_i=1
//  snap_i       in   snapshot strobe (CL_DBG_SNAPSHOT_EN builds only)
//  rd_req_i     in   read request, accepted every cycle
//  rd_addr_i    in   0..NUM_CH-1 counter, NUM_CH overflow flags, above: zero
//  rd_ack_o     out  read data valid, one cycle after rd_req_i
//  rd_data_o    out  read data, holds when rd_ack_o=0
//  ovf_o        out  live sticky overflow flags
// Configuration macro: CL_DBG_SNAPSHOT_EN (counter reads return shadow copies)
module cl_dbg_counter_bank
   import cl_dbg_pkg::*;
#(
   parameter  int unsigned NUM_CH    = DBG_NUM_CH_DEFAULT,
   parameter  int unsigned CNT_W     = 32'd32,
   parameter  int unsigned WRAP_MODE = 32'd0,
   localparam int unsigned ADDR_W    = $clog2(NUM_CH + 32'd1)
) (
   input  logic              clk_main_a0,
   input  logic              rst_main_n,
   input  logic              cnt_en_i,
   input  logic [NUM_CH-1:0] inc_i,
   input  logic              clr_i,
   input  logic [NUM_CH-1:0] clr_mask_i,
   input  logic              snap_i,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_ack_o,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic [NUM_CH-1:0] ovf_o
);

   // Overflow vector is truncated when there are more channels than data bits
   localparam int unsigned OVF_BITS = (NUM_CH < CNT_W) ? NUM_CH : CNT_W;

   logic [CNT_W-1:0]  cnt_val_s [NUM_CH];
   logic [NUM_CH-1:0] ovf_s;
   logic [CNT_W-1:0]  ovf_ext_s;
   logic [CNT_W-1:0]  cnt_pick_s;
   logic [CNT_W-1:0]  rd_mux_s;
   rd_sel_e           rd_sel_s;
   logic              rd_ack_r;
   logic [CNT_W-1:0]  rd_data_r;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      cl_dbg_counter #(
         .CNT_W     (CNT_W),
         .WRAP_MODE (WRAP_MODE)
      ) u_cnt (
         .clk_main_a0 (clk_main_a0),
         .rst_main_n  (rst_main_n),
         .cnt_en_i    (cnt_en_i),
         .inc_i       (inc_i[c]),
         .clr_i       (clr_i & clr_mask_i[c]),
         .snap_i      (snap_i),
         .rd_val_o    (cnt_val_s[c]),
         .ovf_o       (ovf_s[c])
      );
   end

   assign ovf_ext_s = CNT_W'(ovf_s[OVF_BITS-1:0]);
   assign ovf_o     = ovf_s;

   // Classify the read address
   always_comb begin
      rd_sel_s = RD_SEL_ZERO;
      if (rd_addr_i < ADDR_W'(NUM_CH)) begin
         rd_sel_s = RD_SEL_CNT;
      end else if (rd_addr_i == ADDR_W'(NUM_CH)) begin
         rd_sel_s = RD_SEL_OVF;
      end else begin
         rd_sel_s = RD_SEL_ZERO;
      end
   end

   // One-hot AND-OR pick of the addressed channel; avoids an out-of-range index
   always_comb begin
      cnt_pick_s = {CNT_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_pick_s = cnt_pick_s | (cnt_val_s[c] & {CNT_W{rd_addr_i == ADDR_W'(c)}});
      end
   end

   // Final read data selection
   always_comb begin
      rd_mux_s = {CNT_W{1'b0}};
      case (rd_sel_s)
         RD_SEL_CNT:  rd_mux_s = cnt_pick_s;
         RD_SEL_OVF:  rd_mux_s = ovf_ext_s;
         RD_SEL_ZERO: rd_mux_s = {CNT_W{1'b0}};
         default:     rd_mux_s = {CNT_W{1'b0}};
      endcase
   end

   // Read response registers: ack mirrors the request, data holds between reads
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         rd_ack_r  <= 1'b0;
         rd_data_r <= {CNT_W{1'b0}};
      end else begin
         rd_ack_r <= rd_req_i;
         if (rd_req_i) begin
            rd_data_r <= rd_mux_s;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_ack_o  = rd_ack_r;
   assign rd_data_o = rd_data_r;

endmodule : cl_dbg_counter_bank

// File: tb/tb_cl_dbg_counter_bank.sv
// Testbench for cl_dbg_counter_bank: two 6-channel, 8-bit banks (saturating
// and wrapping) share one stimulus stream and are compared each cycle against
// an arithmetic reference model, plus a directed table and corner sequences.
module tb_cl_dbg_counter_bank;

   localparam int NCH  = 6;
   localparam int CW   = 8;
   localparam int AW   = 3;
   localparam int CMAX = 255;
`ifdef CL_DBG_SNAPSHOT_EN
   localparam bit SNAP_BUILD = 1'b1;
`else
   localparam bit SNAP_BUILD = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [NCH-1:0] inc;
   logic           clr;
   logic [NCH-1:0] mask;
   logic           snap;
   logic           req;
   logic [AW-1:0]  addr;

   logic           ack_s, ack_w;
   logic [CW-1:0]  data_s, data_w;
   logic [NCH-1:0] ovf_s, ovf_w;

   int checks   = 0;
   int failures = 0;

   // reference model state: index 0 = saturating bank, 1 = wrapping bank
   int             m_cnt [2][NCH];
   int             m_sh  [2][NCH];
   logic [NCH-1:0] m_ovf [2];
   logic           m_ack [2];
   logic [CW-1:0]  m_data[2];

   typedef struct {
      logic           en;
      logic [NCH-1:0] inc;
      logic           clr;
      logic [NCH-1:0] mask;
      logic           req;
      logic [AW-1:0]  addr;
      logic           exp_ack;
      logic [CW-1:0]  exp_live;
      logic [CW-1:0]  exp_snap;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   cl_dbg_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .WRAP_MODE(0)) u_sat (
      .clk_main_a0 (clk),   .rst_main_n (rst_n), .cnt_en_i (en),
      .inc_i       (inc),   .clr_i      (clr),   .clr_mask_i (mask),
      .snap_i      (snap),  .rd_req_i   (req),   .rd_addr_i  (addr),
      .rd_ack_o    (ack_s), .rd_data_o  (data_s), .ovf_o     (ovf_s)
   );

   cl_dbg_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .WRAP_MODE(1)) u_wrap (
      .clk_main_a0 (clk),   .rst_main_n (rst_n), .cnt_en_i (en),
      .inc_i       (inc),   .clr_i      (clr),   .clr_mask_i (mask),
      .snap_i      (snap),  .rd_req_i   (req),   .rd_addr_i  (addr),
      .rd_ack_o    (ack_w), .rd_data_o  (data_w), .ovf_o     (ovf_w)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[m][c] = 0;
            m_sh[m][c]  = 0;
         end
         m_ovf[m]  = '0;
         m_ack[m]  = 1'b0;
         m_data[m] = '0;
      end
   endtask

   function automatic int read_val(int m, int a);
      if (a < NCH) return SNAP_BUILD ? m_sh[m][a] : m_cnt[m][a];
      else if (a == NCH) return int'(m_ovf[m]);
      else return 0;
   endfunction

   // one clock edge of the specification's rules, read taken from pre-edge state
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (req) begin
            m_ack[m]  = 1'b1;
            m_data[m] = CW'(read_val(m, int'(addr)));
         end else begin
            m_ack[m] = 1'b0;
         end
         if (snap) begin
            for (int c = 0; c < NCH; c++) m_sh[m][c] = m_cnt[m][c];
         end
         for (int c = 0; c < NCH; c++) begin
            if (clr && mask[c]) begin
               m_cnt[m][c] = 0;
               m_ovf[m][c] = 1'b0;
            end else if (en && inc[c]) begin
               if (m_cnt[m][c] == CMAX) m_ovf[m][c] = 1'b1;
               if (m == 1) m_cnt[m][c] = (m_cnt[m][c] + 1) % (CMAX + 1);
               else        m_cnt[m][c] = (m_cnt[m][c] + 1 > CMAX) ? CMAX : m_cnt[m][c] + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("mdl ack sat",  32'(ack_s),  32'(m_ack[0]));
      chk("mdl data sat", 32'(data_s), 32'(m_data[0]));
      chk("mdl ovf sat",  32'(ovf_s),  32'(m_ovf[0]));
      chk("mdl ack wrap", 32'(ack_w),  32'(m_ack[1]));
      chk("mdl data wrap",32'(data_w), 32'(m_data[1]));
      chk("mdl ovf wrap", 32'(ovf_w),  32'(m_ovf[1]));
   endtask

   task automatic idle();
      en = 1'b1; inc = '0; clr = 1'b0; mask = '0; snap = 1'b0; req = 1'b0; addr = '0;
   endtask

   // snapshot cycle (idle without the snapshot build) followed by one read
   task automatic read_chk(input string nm, input logic [AW-1:0] a,
                           input logic [CW-1:0] exp_s, input logic [CW-1:0] exp_w);
      idle(); snap = 1'b1; tick();
      snap = 1'b0; req = 1'b1; addr = a; tick();
      idle();
      chk({nm, " ack sat"},  32'(ack_s),  32'd1);
      chk({nm, " ack wrap"}, 32'(ack_w),  32'd1);
      chk({nm, " sat"},      32'(data_s), 32'(exp_s));
      chk({nm, " wrap"},     32'(data_w), 32'(exp_w));
   endtask

   initial begin
      logic [CW-1:0] exp_d;

      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst ack",  32'(ack_s | ack_w), 32'd0);
      chk("rst data sat",  32'(data_s), 32'd0);
      chk("rst data wrap", 32'(data_w), 32'd0);
      chk("rst ovf",  32'(ovf_s | ovf_w), 32'd0);
      rst_n = 1'b1;

      // directed table: en, inc, clr, mask, req, addr, ack, live data, snapshot data
      tbl[0] = '{1'b1, 6'h01, 1'b0, 6'h00, 1'b1, 3'd0, 1'b1, 8'h00, 8'h00};
      tbl[1] = '{1'b1, 6'h03, 1'b0, 6'h00, 1'b1, 3'd0, 1'b1, 8'h01, 8'h00};
      tbl[2] = '{1'b0, 6'h3F, 1'b0, 6'h00, 1'b1, 3'd1, 1'b1, 8'h01, 8'h00};
      tbl[3] = '{1'b1, 6'h00, 1'b0, 6'h00, 1'b0, 3'd0, 1'b0, 8'h01, 8'h00};
      tbl[4] = '{1'b1, 6'h00, 1'b1, 6'h01, 1'b1, 3'd0, 1'b1, 8'h02, 8'h00};
      tbl[5] = '{1'b1, 6'h00, 1'b0, 6'h00, 1'b1, 3'd0, 1'b1, 8'h00, 8'h00};
      tbl[6] = '{1'b1, 6'h00, 1'b0, 6'h00, 1'b1, 3'd1, 1'b1, 8'h01, 8'h00};
      tbl[7] = '{1'b1, 6'h00, 1'b0, 6'h00, 1'b1, 3'd7, 1'b1, 8'h00, 8'h00};
      tbl[8] = '{1'b1, 6'h00, 1'b0, 6'h00, 1'b1, 3'd6, 1'b1, 8'h00, 8'h00};
      for (int i = 0; i < 9; i++) begin
         en = tbl[i].en; inc = tbl[i].inc; clr = tbl[i].clr; mask = tbl[i].mask;
         snap = 1'b0; req = tbl[i].req; addr = tbl[i].addr;
         tick();
         exp_d = SNAP_BUILD ? tbl[i].exp_snap : tbl[i].exp_live;
         chk($sformatf("tbl%0d ack", i),  32'(ack_s),  32'(tbl[i].exp_ack));
         chk($sformatf("tbl%0d data", i), 32'(data_s), 32'(exp_d));
         chk($sformatf("tbl%0d dwrap", i),32'(data_w), 32'(exp_d));
         chk($sformatf("tbl%0d ovf", i),  32'(ovf_s),  32'd0);
      end
      idle();

      // reset in the middle of counting
      inc = 6'b000001; repeat (10) tick();
      idle(); snap = 1'b1; tick();
      snap = 1'b0; req = 1'b1; addr = 3'd0; tick();
      idle();
      chk("t1 pre data", 32'(data_s), 32'd10);
      #2 rst_n = 1'b0;
      #1;
      chk("t1 async ack",  32'(ack_s | ack_w), 32'd0);
      chk("t1 async data", 32'(data_s | data_w), 32'd0);
      chk("t1 async ovf",  32'(ovf_s | ovf_w), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      read_chk("t1 rd0", 3'd0, 8'h00, 8'h00);

      // 260 increments on ch1: saturate vs wrap
      idle(); clr = 1'b1; mask = '1; tick();
      idle(); inc = 6'b000010; repeat (260) tick();
      read_chk("t2 ch1", 3'd1, 8'hFF, 8'h04);
      chk("t2 ovf1 sat",  32'(ovf_s[1]), 32'd1);
      chk("t2 ovf1 wrap", 32'(ovf_w[1]), 32'd1);

      // clear with same-cycle increment on the cleared channel
      inc = 6'b000011; tick();
      clr = 1'b1; mask = 6'b000010; inc = 6'b000011; tick();
      idle();
      chk("t3 ovf sat",  32'(ovf_s), 32'd0);
      chk("t3 ovf wrap", 32'(ovf_w), 32'd0);
      read_chk("t3 ch1", 3'd1, 8'h00, 8'h00);
      read_chk("t3 ch0", 3'd0, 8'h02, 8'h02);

      // global enable low freezes counts but not clear
      idle(); en = 1'b0; inc = 6'h3F; repeat (20) tick();
      read_chk("t4 ch0 frozen", 3'd0, 8'h02, 8'h02);
      idle(); en = 1'b0; inc = 6'h3F; clr = 1'b1; mask = 6'h3F; tick();
      read_chk("t4 ch0 clr", 3'd0, 8'h00, 8'h00);

      // back-to-back reads: counter, overflow vector, out of range
      idle(); inc = 6'b100001; repeat (3) tick();
      inc = 6'b100000; repeat (253) tick();
      idle(); snap = 1'b1; tick();
      snap = 1'b0; req = 1'b1; addr = 3'd0; tick();
      chk("t5 a0 ack", 32'(ack_s & ack_w), 32'd1);
      chk("t5 a0 sat", 32'(data_s), 32'd3);
      chk("t5 a0 wrap",32'(data_w), 32'd3);
      addr = 3'd6; tick();
      chk("t5 a6 ack", 32'(ack_s & ack_w), 32'd1);
      chk("t5 a6 sat", 32'(data_s), 32'h20);
      chk("t5 a6 wrap",32'(data_w), 32'h20);
      addr = 3'd7; tick();
      chk("t5 a7 ack", 32'(ack_s & ack_w), 32'd1);
      chk("t5 a7 data",32'(data_s | data_w), 32'd0);
      addr = 3'd6; tick();
      req = 1'b0; tick();
      chk("t5 hold ack",  32'(ack_s | ack_w), 32'd0);
      chk("t5 hold sat",  32'(data_s), 32'h20);
      chk("t5 hold wrap", 32'(data_w), 32'h20);
      idle();

      // snapshot taken in the same cycle as an increment
      clr = 1'b1; mask = '1; tick();
      idle(); inc = 6'b000100; repeat (7) tick();
      snap = 1'b1; tick();
      snap = 1'b0; repeat (3) tick();
      idle(); req = 1'b1; addr = 3'd2; tick();
      chk("t6 rd2 sat",  32'(data_s), SNAP_BUILD ? 32'd7 : 32'd11);
      chk("t6 rd2 wrap", 32'(data_w), SNAP_BUILD ? 32'd7 : 32'd11);
      tick();
      chk("t6 rd2 again", 32'(data_s), SNAP_BUILD ? 32'd7 : 32'd11);
      idle();

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         en   = ($urandom_range(0, 7) != 0);
         inc  = NCH'($urandom);
         clr  = ($urandom_range(0, 299) == 0);
         mask = NCH'($urandom);
         snap = ($urandom_range(0, 15) == 0);
         req  = 1'($urandom_range(0, 1));
         addr = AW'($urandom_range(0, 7));
         tick();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cl_dbg_counter_bank
